memwb_stage: RTL and testbench

//  MEM->WB pipeline register and writeback formatter, directly downstream of the dbus memory stage.

---
 rtl/memwb_stage_pkg.sv | 36 +++
 rtl/memwb_stage_load_extend.sv | 40 ++++
 rtl/memwb_stage.sv | 115 +++++++++++
 tb/tb_memwb_stage.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memwb_stage_pkg.sv
// memwb_stage_pkg: load-select encodings shared by the MEM->WB stage and any
// other consumer of raw dbus read words (e.g. a future MMIO/uncached path).
//   LSEL_W          width of the load-select code
//   lsel_e          load kinds; LSEL_NONE marks a non-load
//   lsel_misaligned helper: is this load kind misaligned at addr_lo
package memwb_stage_pkg;

  localparam int LSEL_W = 3;

  typedef enum logic [LSEL_W-1:0] {
    LSEL_NONE = 3'd0,
    LSEL_LB   = 3'd1,
    LSEL_LH   = 3'd2,
    LSEL_LW   = 3'd3,
    LSEL_LD   = 3'd4,
    LSEL_LBU  = 3'd5,
    LSEL_LHU  = 3'd6,
    LSEL_LWU  = 3'd7
  } lsel_e;

  // Byte loads can never be misaligned; wider loads need natural alignment
  // inside the 8-byte dbus word.
  function automatic logic lsel_misaligned(input logic [LSEL_W-1:0] lsel,
                                           input logic [2:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (lsel)
      LSEL_LH, LSEL_LHU: mis = addr_lo[0];
      LSEL_LW, LSEL_LWU: mis = |addr_lo[1:0];
      LSEL_LD:           mis = |addr_lo;
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memwb_stage_load_extend.sv
// load_extend: combinational load formatter.
// Shifts the addressed lane of an 8-byte-aligned dbus word down to bit 0,
// then sign- or zero-extends it according to the load kind.
//   in_rdata    raw dbus read word
//   in_addr_lo  byte offset inside the word
//   in_lsel     load kind (memwb_stage_pkg::lsel_e encoding)
//   o_data      formatted load value (0 for LSEL_NONE)
//   o_misalign  load kind is not naturally aligned at in_addr_lo
module load_extend
  import memwb_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]   in_rdata,
  input  logic [2:0]        in_addr_lo,
  input  logic [LSEL_W-1:0] in_lsel,
  output logic [XLEN-1:0]   o_data,
  output logic              o_misalign
);

  logic [XLEN-1:0] w_lane;

  assign w_lane     = in_rdata >> {in_addr_lo, 3'b000};
  assign o_misalign = lsel_misaligned(in_lsel, in_addr_lo);

  always_comb begin
    o_data = '0;
    case (in_lsel)
      LSEL_LB:  o_data = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
      LSEL_LBU: o_data = {{(XLEN-8){1'b0}}, w_lane[7:0]};
      LSEL_LH:  o_data = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
      LSEL_LHU: o_data = {{(XLEN-16){1'b0}}, w_lane[15:0]};
      LSEL_LW:  o_data = {{(XLEN-32){w_lane[31]}}, w_lane[31:0]};
      LSEL_LWU: o_data = {{(XLEN-32){1'b0}}, w_lane[31:0]};
      LSEL_LD:  o_data = w_lane;
      default:  o_data = '0;
    endcase
  end

endmodule

// File: rtl/memwb_stage.sv
// memwb_stage: MEM->WB pipeline register and writeback formatter.
// Formats load data from the dbus word, selects load vs ALU result, and
// registers the regfile write, commit info and a retired-instruction counter.
//   clk, reset      clock (posedge) and async active-low reset
//   in_valid        MEM holds a real instruction
//   stall_in        MEM still busy on dbus (or global stall): insert bubble
//   flush           kill the instruction being captured
//   in_pc/in_instr  commit info
//   in_rd/in_wen    regfile write request
//   in_lsel         load kind, LSEL_NONE for non-loads
//   in_addr_lo      dbus byte offset
//   in_rdata        raw dbus read word
//   in_alu          result for non-loads
//   wb_*            registered writeback / commit outputs
//   fwd_valid       wb_valid & wb_wen for the bypass network
//   instret         committed-instruction count, wraps mod 2^64
module memwb_stage
  import memwb_stage_pkg::*;
#(
  parameter int          XLEN        = 64,
  parameter int          REG_AW      = 5,
  // Counter value after reset; 0 in any real build.
  parameter logic [63:0] INSTRET_RST = 64'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall_in,
  input  logic              flush,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_instr,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  input  logic [LSEL_W-1:0] in_lsel,
  input  logic [2:0]        in_addr_lo,
  input  logic [XLEN-1:0]   in_rdata,
  input  logic [XLEN-1:0]   in_alu,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_pc,
  output logic [31:0]       wb_instr,
  output logic [REG_AW-1:0] wb_rd,
  output logic              wb_wen,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_misalign,
  output logic              fwd_valid,
  output logic [63:0]       instret
);

  logic [XLEN-1:0]   w_load_data;
  logic              w_misalign;
  logic [XLEN-1:0]   w_data;
  logic              w_wen;

  logic              r_wb_valid;
  logic [XLEN-1:0]   r_wb_pc;
  logic [31:0]       r_wb_instr;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_wen;
  logic [XLEN-1:0]   r_wb_data;
  logic              r_wb_misalign;
  logic [63:0]       r_instret;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .in_rdata   (in_rdata),
    .in_addr_lo (in_addr_lo),
    .in_lsel    (in_lsel),
    .o_data     (w_load_data),
    .o_misalign (w_misalign)
  );

  assign w_data = (in_lsel == LSEL_NONE) ? in_alu : w_load_data;
  // x0 is hardwired zero and a dropped misaligned load must not write.
  assign w_wen  = in_valid & in_wen & (in_rd != '0) & ~w_misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_valid    <= 1'b0;
      r_wb_pc       <= '0;
      r_wb_instr    <= '0;
      r_wb_rd       <= '0;
      r_wb_wen      <= 1'b0;
      r_wb_data     <= '0;
      r_wb_misalign <= 1'b0;
      r_instret     <= INSTRET_RST;
    end else begin
      if (r_wb_valid)
        r_instret <= r_instret + 64'd1;
      // Flush and stall both produce a bubble; data fields hold so the
      // bypass tap never sees a half-formed value.
      if (flush || stall_in) begin
        r_wb_valid <= 1'b0;
        r_wb_wen   <= 1'b0;
      end else begin
        r_wb_valid    <= in_valid;
        r_wb_pc       <= in_pc;
        r_wb_instr    <= in_instr;
        r_wb_rd       <= in_rd;
        r_wb_wen      <= w_wen;
        r_wb_data     <= w_data;
        r_wb_misalign <= w_misalign;
      end
    end
  end

  assign wb_valid    = r_wb_valid;
  assign wb_pc       = r_wb_pc;
  assign wb_instr    = r_wb_instr;
  assign wb_rd       = r_wb_rd;
  assign wb_wen      = r_wb_wen;
  assign wb_data     = r_wb_data;
  assign wb_misalign = r_wb_misalign;
  assign fwd_valid   = r_wb_valid & r_wb_wen;
  assign instret     = r_instret;

endmodule

// File: tb/tb_memwb_stage.sv
module tb_memwb_stage;
  import memwb_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid, stall_in, flush, in_wen;
  logic [63:0] in_pc, in_rdata, in_alu;
  logic [31:0] in_instr;
  logic [4:0]  in_rd;
  logic [2:0]  in_lsel, in_addr_lo;

  logic        wb_valid, wb_wen, wb_misalign, fwd_valid;
  logic [63:0] wb_pc, wb_data, instret;
  logic [31:0] wb_instr;
  logic [4:0]  wb_rd;

  logic        w2_valid, w2_wen, w2_misalign, w2_fwd;
  logic [63:0] w2_pc, w2_data, w2_instret;
  logic [31:0] w2_instr;
  logic [4:0]  w2_rd;

  int errors = 0;
  int checks = 0;

  memwb_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall_in(stall_in), .flush(flush),
    .in_pc(in_pc), .in_instr(in_instr), .in_rd(in_rd), .in_wen(in_wen), .in_lsel(in_lsel),
    .in_addr_lo(in_addr_lo), .in_rdata(in_rdata), .in_alu(in_alu),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .wb_data(wb_data), .wb_misalign(wb_misalign), .fwd_valid(fwd_valid), .instret(instret)
  );

  // Second instance whose counter starts at all-ones, to exercise the wrap.
  memwb_stage #(.INSTRET_RST(64'hFFFF_FFFF_FFFF_FFFF)) u_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall_in(stall_in), .flush(flush),
    .in_pc(in_pc), .in_instr(in_instr), .in_rd(in_rd), .in_wen(in_wen), .in_lsel(in_lsel),
    .in_addr_lo(in_addr_lo), .in_rdata(in_rdata), .in_alu(in_alu),
    .wb_valid(w2_valid), .wb_pc(w2_pc), .wb_instr(w2_instr), .wb_rd(w2_rd), .wb_wen(w2_wen),
    .wb_data(w2_data), .wb_misalign(w2_misalign), .fwd_valid(w2_fwd), .instret(w2_instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [2:0] lsel, input logic [2:0] addr, input logic [63:0] rdata,
                           input logic [63:0] alu, input logic [4:0] rd, input logic wen);
    in_valid = 1'b1; stall_in = 1'b0; flush = 1'b0;
    in_lsel = lsel; in_addr_lo = addr; in_rdata = rdata; in_alu = alu;
    in_rd = rd; in_wen = wen;
    in_pc = in_pc + 64'd4;
    in_instr = in_instr + 32'd1;
  endtask

  task automatic set_idle();
    in_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    in_lsel = LSEL_NONE; in_addr_lo = 3'd0; in_rdata = 64'd0;
    in_alu = 64'hDEAD_0000_0000_BEEF; in_rd = 5'd1; in_wen = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b1; stall_in = 1'b0; flush = 1'b0;
    in_pc = {$urandom, $urandom}; in_instr = $urandom; in_rd = 5'd3; in_wen = 1'b1;
    in_lsel = LSEL_LD; in_addr_lo = 3'd0; in_rdata = {$urandom, $urandom}; in_alu = {$urandom, $urandom};
    repeat (3) tick();
    in_pc = 64'h1000; in_instr = 32'h0;
    set_idle();
    reset = 1'b1;
    #1;
    checks++;
    if ({wb_valid, wb_wen, wb_misalign, fwd_valid} !== 4'b0 || wb_pc !== 64'd0 || wb_instr !== 32'd0 ||
        wb_rd !== 5'd0 || wb_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b wen=%b pc=%h data=%h rd=%0d exp all zero",
               wb_valid, wb_wen, wb_pc, wb_data, wb_rd);
    end
    checks++;
    if (instret !== 64'd0) begin
      errors++; $display("FAIL reset_instret got=%h exp=0", instret);
    end
    checks++;
    if (w2_instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL reset_wrap_instret got=%h exp=ffffffffffffffff", w2_instret);
    end
    @(negedge clk);
  endtask

  task automatic test_lb();
    set_instr(LSEL_LB, 3'd1, 64'h0000_0000_0000_8000, 64'h0, 5'd5, 1'b1);
    tick();
    checks++;
    if (wb_data !== 64'hFFFF_FFFF_FFFF_FF80) begin
      errors++; $display("FAIL lb_data got=%h exp=ffffffffffffff80", wb_data);
    end
    checks++;
    if ({wb_valid, wb_wen, fwd_valid, wb_misalign} !== 4'b1110 || wb_rd !== 5'd5) begin
      errors++; $display("FAIL lb_ctrl got valid=%b wen=%b fwd=%b mis=%b rd=%0d exp 1 1 1 0 5",
                         wb_valid, wb_wen, fwd_valid, wb_misalign, wb_rd);
    end
    checks++;
    if (wb_pc !== 64'h1004 || wb_instr !== 32'd1) begin
      errors++; $display("FAIL lb_commit got pc=%h instr=%h exp pc=1004 instr=1", wb_pc, wb_instr);
    end
    set_idle();
    tick();
    checks++;
    if (wb_valid !== 1'b0 || instret !== 64'd1) begin
      errors++; $display("FAIL lb_retire got valid=%b instret=%0d exp valid=0 instret=1", wb_valid, instret);
    end
    checks++;
    if (w2_instret !== 64'd0) begin
      errors++; $display("FAIL instret_wrap got=%h exp=0", w2_instret);
    end
  endtask

  task automatic test_word_loads();
    set_instr(LSEL_LWU, 3'd4, 64'h8765_4321_0000_0000, 64'h0, 5'd6, 1'b1);
    tick();
    checks++;
    if (wb_data !== 64'h0000_0000_8765_4321) begin
      errors++; $display("FAIL lwu_data got=%h exp=0000000087654321", wb_data);
    end
    set_instr(LSEL_LW, 3'd4, 64'h8765_4321_0000_0000, 64'h0, 5'd6, 1'b1);
    tick();
    checks++;
    if (wb_data !== 64'hFFFF_FFFF_8765_4321 || wb_valid !== 1'b1) begin
      errors++; $display("FAIL lw_data got=%h valid=%b exp=ffffffff87654321 valid=1", wb_data, wb_valid);
    end
  endtask

  task automatic test_other_formats();
    set_instr(LSEL_LH, 3'd6, 64'h8765_4321_0000_0000, 64'h0, 5'd8, 1'b1);
    tick();
    checks++;
    if (wb_data !== 64'hFFFF_FFFF_FFFF_8765) begin
      errors++; $display("FAIL lh_data got=%h exp=ffffffffffff8765", wb_data);
    end
    set_instr(LSEL_LHU, 3'd6, 64'h8765_4321_0000_0000, 64'h0, 5'd8, 1'b1);
    tick();
    checks++;
    if (wb_data !== 64'h0000_0000_0000_8765) begin
      errors++; $display("FAIL lhu_data got=%h exp=0000000000008765", wb_data);
    end
    set_instr(LSEL_LBU, 3'd1, 64'h0000_0000_0000_8000, 64'h0, 5'd8, 1'b1);
    tick();
    checks++;
    if (wb_data !== 64'h0000_0000_0000_0080) begin
      errors++; $display("FAIL lbu_data got=%h exp=0000000000000080", wb_data);
    end
    set_instr(LSEL_LD, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd8, 1'b1);
    tick();
    checks++;
    if (wb_data !== 64'h0123_4567_89AB_CDEF || wb_misalign !== 1'b0) begin
      errors++; $display("FAIL ld_data got=%h mis=%b exp=0123456789abcdef mis=0", wb_data, wb_misalign);
    end
    set_instr(LSEL_NONE, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_CAFE, 5'd9, 1'b1);
    tick();
    checks++;
    if (wb_data !== 64'h0000_0000_0000_CAFE || wb_wen !== 1'b1 || wb_rd !== 5'd9) begin
      errors++; $display("FAIL alu_select got data=%h wen=%b rd=%0d exp cafe 1 9", wb_data, wb_wen, wb_rd);
    end
    set_idle();
    tick();
    checks++;
    if (instret !== 64'd8) begin
      errors++; $display("FAIL formats_instret got=%0d exp=8", instret);
    end
  endtask

  task automatic test_stall();
    set_instr(LSEL_NONE, 3'd0, 64'h0, 64'h0000_0000_0000_1234, 5'd7, 1'b1);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (wb_valid !== 1'b0 || wb_wen !== 1'b0 || wb_data !== 64'hDEAD_0000_0000_BEEF) begin
        errors++; $display("FAIL stall_bubble cyc=%0d got valid=%b wen=%b data=%h exp 0 0 dead00000000beef",
                           i, wb_valid, wb_wen, wb_data);
      end
    end
    stall_in = 1'b0;
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_wen !== 1'b1 || wb_data !== 64'h0000_0000_0000_1234) begin
      errors++; $display("FAIL stall_commit got valid=%b wen=%b data=%h exp 1 1 1234", wb_valid, wb_wen, wb_data);
    end
    set_idle();
    tick();
    checks++;
    if (wb_valid !== 1'b0 || instret !== 64'd9) begin
      errors++; $display("FAIL stall_once got valid=%b instret=%0d exp valid=0 instret=9", wb_valid, instret);
    end
  endtask

  task automatic test_misalign();
    set_instr(LSEL_LD, 3'd4, 64'h1111_2222_3333_4444, 64'h0, 5'd3, 1'b1);
    tick();
    checks++;
    if ({wb_valid, wb_wen, wb_misalign, fwd_valid} !== 4'b1010) begin
      errors++; $display("FAIL ld_misalign got valid=%b wen=%b mis=%b fwd=%b exp 1 0 1 0",
                         wb_valid, wb_wen, wb_misalign, fwd_valid);
    end
    set_instr(LSEL_LW, 3'd2, 64'h1111_2222_3333_4444, 64'h0, 5'd3, 1'b1);
    tick();
    checks++;
    if (wb_misalign !== 1'b1 || wb_wen !== 1'b0) begin
      errors++; $display("FAIL lw_misalign got mis=%b wen=%b exp 1 0", wb_misalign, wb_wen);
    end
    set_instr(LSEL_LH, 3'd1, 64'h1111_2222_3333_4444, 64'h0, 5'd3, 1'b1);
    tick();
    checks++;
    if (wb_misalign !== 1'b1 || wb_wen !== 1'b0) begin
      errors++; $display("FAIL lh_misalign got mis=%b wen=%b exp 1 0", wb_misalign, wb_wen);
    end
    set_instr(LSEL_LH, 3'd2, 64'h0000_0000_F00D_0000, 64'h0, 5'd3, 1'b1);
    tick();
    checks++;
    if (wb_misalign !== 1'b0 || wb_wen !== 1'b1 || wb_data !== 64'hFFFF_FFFF_FFFF_F00D) begin
      errors++; $display("FAIL lh_aligned got mis=%b wen=%b data=%h exp 0 1 fffffffffffff00d",
                         wb_misalign, wb_wen, wb_data);
    end
    set_instr(LSEL_NONE, 3'd0, 64'h0, 64'h0000_0000_0000_0777, 5'd0, 1'b1);
    tick();
    checks++;
    if ({wb_valid, wb_wen, wb_misalign} !== 3'b100 || wb_data !== 64'h777) begin
      errors++; $display("FAIL x0_gate got valid=%b wen=%b mis=%b data=%h exp 1 0 0 777",
                         wb_valid, wb_wen, wb_misalign, wb_data);
    end
    set_idle();
    tick();
    checks++;
    if (instret !== 64'd14) begin
      errors++; $display("FAIL misalign_instret got=%0d exp=14", instret);
    end
  endtask

  task automatic test_flush();
    set_instr(LSEL_NONE, 3'd0, 64'h0, 64'h0000_0000_0000_0ABC, 5'd2, 1'b1);
    flush = 1'b1; stall_in = 1'b1;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_wen !== 1'b0) begin
      errors++; $display("FAIL flush_stall got valid=%b wen=%b exp 0 0", wb_valid, wb_wen);
    end
    stall_in = 1'b0;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_wen !== 1'b0 || wb_data !== 64'hDEAD_0000_0000_BEEF) begin
      errors++; $display("FAIL flush_only got valid=%b wen=%b data=%h exp 0 0 dead00000000beef",
                         wb_valid, wb_wen, wb_data);
    end
    set_idle();
    tick();
    checks++;
    if (instret !== 64'd14) begin
      errors++; $display("FAIL flush_instret got=%0d exp=14", instret);
    end
  endtask

  task automatic test_reset_mid_stall();
    set_instr(LSEL_NONE, 3'd0, 64'h0, 64'h0000_0000_0000_0055, 5'd4, 1'b1);
    stall_in = 1'b1;
    tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (wb_valid !== 1'b0 || wb_data !== 64'd0 || instret !== 64'd0 || w2_instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL async_reset got valid=%b data=%h instret=%h wrap=%h exp 0 0 0 ffffffffffffffff",
                         wb_valid, wb_data, instret, w2_instret);
    end
    @(negedge clk);
    reset = 1'b1;
    stall_in = 1'b0;
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_wen !== 1'b1 || wb_data !== 64'h55 || wb_rd !== 5'd4) begin
      errors++; $display("FAIL post_reset_capture got valid=%b wen=%b data=%h rd=%0d exp 1 1 55 4",
                         wb_valid, wb_wen, wb_data, wb_rd);
    end
    set_idle();
    tick();
    checks++;
    if (instret !== 64'd1 || w2_instret !== 64'd0) begin
      errors++; $display("FAIL post_reset_instret got=%0d wrap=%h exp 1 0", instret, w2_instret);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_word_loads();
    test_other_formats();
    test_stall();
    test_misalign();
    test_flush();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
